// File: rtl/bnn_pkg.sv
// Shared sizing and state encoding for the BNN inference sequencer.
package bnn_pkg;

  localparam int unsigned N_FEAT     = 16;
  localparam int unsigned FEAT_W     = 7;
  localparam int unsigned N_CLASS    = 10;
  localparam int unsigned SCORE_W    = 5;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned CLS_W      = 4;

  localparam int unsigned FCNT_W = $clog2(N_FEAT);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    SCAN   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bnn_argmax_seq.sv
// Serial argmax: one score per sample; start reloads, later samples win only on strictly greater.
module bnn_argmax_seq
  import bnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic               start,
  input  logic [CLS_W-1:0]   sample_idx,
  input  logic [SCORE_W-1:0] score_in,
  output logic [SCORE_W-1:0] best,
  output logic [CLS_W-1:0]   best_idx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
    end else if (sample && (start || (score_in > best))) begin
      best     <= score_in;
      best_idx <= sample_idx;
    end
  end

endmodule

// File: rtl/bnn_infer_seq.sv
// Frame assembly, settle wait, class scan and result handshake around the combinational BNN datapath.
module bnn_infer_seq
  import bnn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FEAT_W-1:0]          in_data,
  output logic [N_FEAT*FEAT_W-1:0]   feat_bus,
  input  logic [N_CLASS*SCORE_W-1:0] score_bus,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLS_W-1:0]           out_class,
  output logic [SCORE_W-1:0]         out_score,
  output logic                       busy
);

  state_t              state;
  logic [FCNT_W-1:0]   feat_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic [CLS_W-1:0]    scan_idx;
  logic [SCORE_W-1:0]  score_sel;

  // Score mux for the class currently being scanned.
  always_comb begin
    score_sel = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (scan_idx == CLS_W'(k)) score_sel = score_bus[k*SCORE_W +: SCORE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      feat_cnt   <= '0;
      settle_cnt <= '0;
      scan_idx   <= '0;
      feat_bus   <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < N_FEAT; i++) begin
              if (feat_cnt == FCNT_W'(i)) feat_bus[i*FEAT_W +: FEAT_W] <= in_data;
            end
            busy <= 1'b1;
            if (feat_cnt == FCNT_W'(N_FEAT - 1)) begin
              feat_cnt <= '0;
              in_ready <= 1'b0;
              state    <= SETTLE;
            end else begin
              feat_cnt <= feat_cnt + FCNT_W'(1);
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYC)) begin
            settle_cnt <= '0;
            scan_idx   <= '0;
            state      <= SCAN;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        SCAN: begin
          if (scan_idx == CLS_W'(N_CLASS - 1)) begin
            scan_idx  <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            scan_idx <= scan_idx + CLS_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  bnn_argmax_seq u_argmax (
    .clk        (clk),
    .rst        (rst),
    .sample     (state == SCAN),
    .start      (scan_idx == '0),
    .sample_idx (scan_idx),
    .score_in   (score_sel),
    .best       (out_score),
    .best_idx   (out_class)
  );

endmodule

// File: tb/tb_bnn_infer_seq.sv
// Directed and randomized checks of bnn_infer_seq against a frame/argmax reference model.
module tb_bnn_infer_seq;
  import bnn_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [FEAT_W-1:0]          in_data;
  logic [N_FEAT*FEAT_W-1:0]   feat_bus;
  logic [N_CLASS*SCORE_W-1:0] score_bus;
  logic                       out_valid;
  logic                       out_ready;
  logic [CLS_W-1:0]           out_class;
  logic [SCORE_W-1:0]         out_score;
  logic                       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int gap_at   = -1;

  logic [FEAT_W-1:0]  feats[N_FEAT];
  logic [FEAT_W-1:0]  ref_slots[N_FEAT];
  logic [SCORE_W-1:0] scores[N_CLASS];

  bnn_infer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .feat_bus  (feat_bus),
    .score_bus (score_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N_FEAT*FEAT_W-1:0] exp_bus();
    logic [N_FEAT*FEAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_FEAT; i++) r[i*FEAT_W +: FEAT_W] = ref_slots[i];
    return r;
  endfunction

  function automatic int exp_score();
    int mx = 0;
    for (int k = 0; k < N_CLASS; k++) if (int'(scores[k]) > mx) mx = int'(scores[k]);
    return mx;
  endfunction

  // Lowest index holding the maximum value.
  function automatic int exp_class();
    int idx = 0;
    int mx  = exp_score();
    for (int k = N_CLASS - 1; k >= 0; k--) if (int'(scores[k]) == mx) idx = k;
    return idx;
  endfunction

  task automatic drive_scores();
    for (int k = 0; k < N_CLASS; k++) score_bus[k*SCORE_W +: SCORE_W] = scores[k];
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N_FEAT; i++) ref_slots[i] = '0;
  endtask

  task automatic random_feats();
    for (int i = 0; i < N_FEAT; i++) feats[i] = FEAT_W'($urandom);
  endtask

  task automatic send_features(input int first, input int last);
    int  i = first;
    int  budget = 0;
    bit  acc;
    while (i <= last && budget < 200) begin
      if (gap_at >= 0 && i == gap_at + 1) begin
        in_valid = 1'b0;
        step();
        gap_at = -1;
      end
      in_valid = 1'b1;
      in_data  = feats[i];
      acc      = in_ready;
      step();
      if (acc) begin
        ref_slots[i] = feats[i];
        i++;
      end
      budget++;
    end
    in_valid = 1'b0;
    if (i <= last) check("send_timeout", 128'(i), 128'(last + 1));
    check("feat_bus", 128'(feat_bus), 128'(exp_bus()));
    if (last == N_FEAT - 1) begin
      check("in_ready_after_frame", 128'(in_ready), 128'(0));
      check("busy_after_frame", 128'(busy), 128'(1));
    end
  endtask

  task automatic wait_result(input bit noise);
    int cyc = 0;
    while (!out_valid && cyc < 100) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = FEAT_W'($urandom);
      step();
      cyc++;
      if (cyc == 1) check("busy_settle", 128'(busy), 128'(1));
    end
    in_valid = 1'b0;
    check("latency", 128'(cyc), 128'(13));
    check("out_class", 128'(out_class), 128'(exp_class()));
    check("out_score", 128'(out_score), 128'(exp_score()));
    check("feat_bus_frozen", 128'(feat_bus), 128'(exp_bus()));
  endtask

  task automatic finish_result(input int hold);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      step();
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_class", 128'(out_class), 128'(exp_class()));
      check("hold_score", 128'(out_score), 128'(exp_score()));
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    step();
    check("valid_drop", 128'(out_valid), 128'(0));
    check("in_ready_reopen", 128'(in_ready), 128'(1));
    check("busy_idle", 128'(busy), 128'(0));
  endtask

  task automatic full_frame(input int hold, input bit noise);
    drive_scores();
    send_features(0, N_FEAT - 1);
    wait_result(noise);
    finish_result(hold);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; score_bus = '0;
    clear_slots();
    step();
    step();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_feat_bus", 128'(feat_bus), 128'(0));
    check("rst_out_class", 128'(out_class), 128'(0));
    check("rst_out_score", 128'(out_score), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    step();
    check("in_ready_after_rst", 128'(in_ready), 128'(1));

    // Directed frame with a gap after feature 5.
    feats  = '{7'd98, 7'd56, 7'd61, 7'd42, 7'd23, 7'd0, 7'd0, 7'd42,
               7'd29, 7'd100, 7'd66, 7'd60, 7'd98, 7'd18, 7'd100, 7'd80};
    scores = '{5'd3, 5'd7, 5'd12, 5'd12, 5'd1, 5'd0, 5'd9, 5'd4, 5'd2, 5'd11};
    gap_at = 5;
    drive_scores();
    send_features(0, N_FEAT - 1);
    check("feat0", 128'(feat_bus[6:0]), 128'(98));
    check("feat15", 128'(feat_bus[111:105]), 128'(80));
    wait_result(1'b1);
    check("directed_class", 128'(out_class), 128'(2));
    check("directed_score", 128'(out_score), 128'(12));
    finish_result(5);
    out_ready = 1'b0;

    // Score boundaries.
    random_feats();
    for (int k = 0; k < N_CLASS; k++) scores[k] = 5'd0;
    full_frame(1, 1'b0);
    out_ready = 1'b0;
    random_feats();
    for (int k = 0; k < N_CLASS; k++) scores[k] = 5'd31;
    full_frame(0, 1'b1);
    out_ready = 1'b0;
    random_feats();
    for (int k = 0; k < N_CLASS; k++) scores[k] = (k == N_CLASS - 1) ? 5'd31 : 5'd30;
    full_frame(2, 1'b0);
    out_ready = 1'b0;

    // Reset mid-frame discards the partial frame.
    random_feats();
    send_features(0, 7);
    rst = 1'b1;
    step();
    clear_slots();
    check("midrst_feat_bus", 128'(feat_bus), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    step();
    check("midrst_in_ready_after", 128'(in_ready), 128'(1));
    random_feats();
    for (int k = 0; k < N_CLASS; k++) scores[k] = SCORE_W'($urandom);
    full_frame(1, 1'b1);
    out_ready = 1'b0;

    // Randomized frames, some with narrow score ranges to force ties.
    for (int r = 0; r < 8; r++) begin
      random_feats();
      for (int k = 0; k < N_CLASS; k++)
        scores[k] = SCORE_W'($urandom_range(0, (r % 2 == 1) ? 3 : 31));
      full_frame($urandom_range(0, 3), 1'(r % 2));
      out_ready = 1'b0;
    end

    // Back-to-back with out_ready tied high; partial second frame keeps old slots.
    out_ready = 1'b1;
    random_feats();
    for (int k = 0; k < N_CLASS; k++) scores[k] = SCORE_W'($urandom);
    full_frame(0, 1'b0);
    random_feats();
    for (int k = 0; k < N_CLASS; k++) scores[k] = SCORE_W'($urandom);
    drive_scores();
    send_features(0, 2);
    send_features(3, N_FEAT - 1);
    wait_result(1'b0);
    finish_result(0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_infer_seq.md
Name: bnn_infer_seq

Overview:
- Sequencing controller for the combinational BNN inference datapath (dense input layer → batch-norm binarizer → XNOR-popcount class scorer).
- Accepts the 16 pen-digit features serially over a valid/ready stream and assembles them into the packed feature bus that drives the datapath.
- Holds that bus stable for a settle window, then scans the 10 packed class popcounts one per cycle to find the argmax.
- Returns the winning class and its score over a valid/ready output handshake.

Parameters:
- N_FEAT, 16, number of input features per frame
- FEAT_W, 7, feature width (unsigned)
- N_CLASS, 10, number of class scores
- SCORE_W, 5, popcount width per class (unsigned)
- SETTLE_CYC, 2, cycles the feature bus is held before the first score is sampled (≥1)
- CLS_W, 4, class index width (≥ clog2(N_CLASS))

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  feature word valid
- in_ready  out  1  controller accepts a feature word
- in_data  in  FEAT_W  feature word; the first word of a frame is feature 0
- feat_bus  out  N_FEAT*FEAT_W  to datapath; feature i at [i*FEAT_W +: FEAT_W]
- score_bus  in  N_CLASS*SCORE_W  from datapath; class k at [k*SCORE_W +: SCORE_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLS_W  argmax class index
- out_score  out  SCORE_W  winning popcount
- busy  out  1  high in any state except LOAD with feature count 0

Behaviour:
- States: LOAD, SETTLE, SCAN, DONE.
- Reset values:
  - state=LOAD, feature count=0, settle count=0, scan index=0.
  - feat_bus=0, out_valid=0, out_class=0, out_score=0.
  - in_ready=1 in the cycle after reset deasserts; in_ready is 0 while rst is high.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, write in_data to slot[count] and increment count.
  - On the handshake with count==N_FEAT-1, clear count and go to SETTLE.
  - Slots not yet rewritten keep their previous frame's value.
- SETTLE:
  - in_ready=0. feat_bus is frozen.
  - Count SETTLE_CYC cycles, then go to SCAN with index=0.
- SCAN, one class per cycle:
  - index 0 loads best=score[0], best_idx=0 unconditionally.
  - For index k>0, update best and best_idx only if score[k] > best (strict).
  - Ties therefore resolve to the lowest index.
  - After index N_CLASS-1, go to DONE.
- DONE:
  - out_valid=1. out_class and out_score hold best_idx and best, stable while out_valid=1.
  - On out_ready, out_valid drops the next cycle and the state returns to LOAD.
- out_valid is registered and never depends combinationally on out_ready.
- Latency: the last input handshake at edge T gives out_valid=1 from edge T+SETTLE_CYC+N_CLASS+1 (13 cycles with defaults).
- feat_bus is driven only from registers and changes only on LOAD handshakes, so score_bus sampled during SCAN always reflects the complete frame.
- No input is accepted during SETTLE, SCAN or DONE; in_valid asserted there is ignored, not buffered.
- out_ready=1 already high when DONE is entered completes the handshake in that first DONE cycle.
- Reset mid-frame or mid-scan: on the next edge every register returns to its reset value and the partial frame is discarded.
- Score comparison is unsigned on SCORE_W bits. All-zero scores give class 0, score 0.

Decomposition:
- Shared package bnn_pkg: N_FEAT, FEAT_W, N_CLASS, SCORE_W, CLS_W and the state enum (LOAD, SETTLE, SCAN, DONE).
- Sub-module bnn_argmax_seq: serial compare/accumulate with start, sample-index, score-in and best/best_idx outputs.
- The controller owns the FSM, feature shift/slot registers and handshakes.

Test Plan:
- Frame 98,56,61,42,23,0,0,42,29,100,66,60,98,18,100,80 with a gap cycle after feature 5 → feat_bus[6:0]=98 and feat_bus[111:105]=80; in_ready=0 from the cycle after the 16th accept.
- score_bus classes 0..9 = 3,7,12,12,1,0,9,4,2,11 → out_class=2, out_score=12, out_valid exactly 13 cycles after the last accept.
- All scores 0 → class 0, score 0. All scores 31 → class 0. Only class 9=31 with others 30 → class 9.
- out_ready held low 5 cycles in DONE → outputs stable, in_ready=0 throughout; a new frame is accepted the cycle after the out_ready handshake.
- rst asserted after 8 features, then a full new frame → result matches the new frame only; in_ready=1 the cycle after rst deasserts.
- Back-to-back frames with out_ready tied high → out_valid pulses one cycle per frame; feat_bus reflects the second frame after its 16th accept.
